// File: rtl/decode_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// decode_pkg : multicycle op encoding; MULTDIV_ACCUM_EN adds the MADD family
// Rev 1.0
// ---------------------------------------------------------------------------
package decode_pkg;

`ifdef MULTDIV_ACCUM_EN
  typedef enum logic [2:0] {
    M_MULT, M_MULTU, M_DIV, M_DIVU, M_MADD, M_MADDU, M_MSUB, M_MSUBU
  } multicycle_t;
`else
  typedef enum logic [1:0] {
    M_MULT, M_MULTU, M_DIV, M_DIVU
  } multicycle_t;
`endif

endpackage
`default_nettype wire

// File: rtl/multdiv_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multdiv_pkg : mult/div sequencer states, defaults and op classification
// Rev 1.0
// ---------------------------------------------------------------------------
package multdiv_pkg;
  import decode_pkg::*;

  localparam int DIV_ITERS_DEF = 32;

  typedef enum logic [2:0] {
    IDLE, MUL, DIV, FIX, DONE
  } mdu_state_t;

  function automatic logic is_div_op(input multicycle_t m);
    return (m == M_DIV) || (m == M_DIVU);
  endfunction

  function automatic logic is_signed_op(input multicycle_t m);
`ifdef MULTDIV_ACCUM_EN
    return (m == M_MULT) || (m == M_DIV) || (m == M_MADD) || (m == M_MSUB);
`else
    return (m == M_MULT) || (m == M_DIV);
`endif
  endfunction

endpackage
`default_nettype wire

// File: rtl/div_iter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// div_iter : restoring radix-2 divider datapath, one quotient bit per step
// Rev 1.0
// ---------------------------------------------------------------------------
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quot,
  output logic [31:0] rem
);

  logic [31:0] dvs_q;
  logic [32:0] partial;
  logic [32:0] trial;

  // partial < 2*divisor always, so bit 32 of the trial is a clean borrow flag
  assign partial = {rem, quot[31]};
  assign trial   = partial - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      quot  <= '0;
      rem   <= '0;
      dvs_q <= '0;
    end else if (load) begin
      quot  <= dividend;
      rem   <= '0;
      dvs_q <= divisor;
    end else if (step) begin
      quot <= {quot[30:0], ~trial[32]};
      rem  <= trial[32] ? partial[31:0] : trial[31:0];
    end
  end

endmodule
`default_nettype wire

// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// multdiv_ctrl : EX-stage multiply/divide sequencer (MULTDIV_ACCUM_EN: MADD/MSUB)
// Rev 1.0
// ---------------------------------------------------------------------------
module multdiv_ctrl
  import decode_pkg::*;
  import multdiv_pkg::*;
#(
  parameter int MUL_LAT   = 3,
  parameter int DIV_ITERS = DIV_ITERS_DEF
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic        flush,
  input  multicycle_t mtype,
  input  logic        is_mul,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] hi_in,
  input  logic [31:0] lo_in,
  output logic        busy,
  output logic        done,
  output logic        hilo_we,
  output logic        gpr_we,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out
);

  localparam int CNT_MAX  = (DIV_ITERS > MUL_LAT) ? DIV_ITERS : MUL_LAT;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int MUL_LAST = (MUL_LAT > 1) ? MUL_LAT - 2 : 0;
  localparam int DIV_LAST = (DIV_ITERS > 0) ? DIV_ITERS - 1 : 0;

  mdu_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  multicycle_t      type_q;
  logic             mul_q;

  logic        accept;
  logic        in_idle;
  logic [31:0] op_a;
  logic [31:0] op_b;
  multicycle_t op_type;
  logic        op_mul;
  logic        op_sgn;
  logic        op_acc;
  logic [63:0] ext_a;
  logic [63:0] ext_b;
  logic [63:0] product;
  logic [63:0] mul_res;
  logic        mul_last;
  logic        mul_fin;

  assign in_idle = (state == IDLE);
  assign accept  = start && !flush && in_idle;
  assign busy    = accept || (state inside {MUL, DIV, FIX});

  // With MUL_LAT==1 the product is written straight from the accept cycle,
  // so the multiplier sees the live operands while idle.
  assign op_a    = in_idle ? src_a  : a_q;
  assign op_b    = in_idle ? src_b  : b_q;
  assign op_type = in_idle ? mtype  : type_q;
  assign op_mul  = in_idle ? is_mul : mul_q;
  assign op_sgn  = is_signed_op(op_type);
  assign ext_a   = {{32{op_sgn & op_a[31]}}, op_a};
  assign ext_b   = {{32{op_sgn & op_b[31]}}, op_b};
  assign product = ext_a * ext_b;

`ifdef MULTDIV_ACCUM_EN
  logic [63:0] acc_q;
  logic        op_sub;

  assign op_acc  = op_type inside {M_MADD, M_MADDU, M_MSUB, M_MSUBU};
  assign op_sub  = op_type inside {M_MSUB, M_MSUBU};
  assign mul_res = !op_acc ? product : (op_sub ? acc_q - product : acc_q + product);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      acc_q <= '0;
    end else if (accept) begin
      acc_q <= {hi_in, lo_in};
    end
  end
`else
  logic unused_hilo;

  assign op_acc      = 1'b0;
  assign mul_res     = product;
  assign unused_hilo = ^{hi_in, lo_in};
`endif

  // Accumulating ops spend one extra MUL cycle on the 64-bit add/subtract.
  assign mul_last = op_acc ? (cnt == CNT_W'(MUL_LAT - 1)) : (cnt == CNT_W'(MUL_LAST));
  assign mul_fin  = !flush && (((state == MUL) && mul_last) ||
                    (accept && !is_div_op(mtype) && (MUL_LAT == 1) && !op_acc));

  logic [31:0] dvd_mag;
  logic [31:0] dvs_mag;
  logic [31:0] quot;
  logic [31:0] rem;

  assign dvd_mag = (op_sgn && src_a[31]) ? -src_a : src_a;
  assign dvs_mag = (op_sgn && src_b[31]) ? -src_b : src_b;

  div_iter u_div (
    .clk      (clk),
    .resetn   (resetn),
    .load     (accept && is_div_op(mtype)),
    .step     (state == DIV),
    .dividend (dvd_mag),
    .divisor  (dvs_mag),
    .quot     (quot),
    .rem      (rem)
  );

  logic        sgn_q;
  logic        neg_q;
  logic        neg_r;
  logic        div_zero_q;
  logic [31:0] fix_hi;
  logic [31:0] fix_lo;

  assign sgn_q      = is_signed_op(type_q);
  assign neg_q      = sgn_q && (a_q[31] ^ b_q[31]);
  assign neg_r      = sgn_q && a_q[31];
  assign div_zero_q = (b_q == '0);
  assign fix_lo     = div_zero_q ? 32'hFFFF_FFFF : (neg_q ? -quot : quot);
  assign fix_hi     = div_zero_q ? a_q : (neg_r ? -rem : rem);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state   <= IDLE;
      cnt     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      type_q  <= M_MULT;
      mul_q   <= 1'b0;
      done    <= 1'b0;
      hilo_we <= 1'b0;
      gpr_we  <= 1'b0;
      hi_out  <= '0;
      lo_out  <= '0;
    end else begin
      done    <= 1'b0;
      hilo_we <= 1'b0;
      gpr_we  <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              a_q    <= src_a;
              b_q    <= src_b;
              type_q <= mtype;
              mul_q  <= is_mul;
              cnt    <= '0;
              if (is_div_op(mtype)) begin
                state <= (src_b == '0) ? FIX : DIV;
              end else if (mul_fin) begin
                state <= DONE;
              end else begin
                state <= MUL;
              end
            end
          end
          MUL: begin
            if (mul_last) state <= DONE;
            else          cnt   <= cnt + CNT_W'(1);
          end
          DIV: begin
            if (cnt == CNT_W'(DIV_LAST)) state <= FIX;
            else                         cnt   <= cnt + CNT_W'(1);
          end
          FIX:     state <= DONE;
          DONE:    state <= IDLE;
          default: state <= IDLE;
        endcase

        if (mul_fin) begin
          done    <= 1'b1;
          hilo_we <= !op_mul;
          gpr_we  <= op_mul;
          hi_out  <= mul_res[63:32];
          lo_out  <= mul_res[31:0];
        end
        if (state == FIX) begin
          done    <= 1'b1;
          hilo_we <= !mul_q;
          gpr_we  <= mul_q;
          hi_out  <= fix_hi;
          lo_out  <= fix_lo;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_multdiv_ctrl : directed vector table plus flush/reset/start corner cases
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_multdiv_ctrl;
  import decode_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start;
  logic        flush;
  multicycle_t mtype;
  logic        is_mul;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic [31:0] hi_in;
  logic [31:0] lo_in;
  logic        busy;
  logic        done;
  logic        hilo_we;
  logic        gpr_we;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  always #5 clk = ~clk;

  multdiv_ctrl #(.MUL_LAT(3), .DIV_ITERS(32)) dut (
    .clk     (clk),
    .resetn  (resetn),
    .start   (start),
    .flush   (flush),
    .mtype   (mtype),
    .is_mul  (is_mul),
    .src_a   (src_a),
    .src_b   (src_b),
    .hi_in   (hi_in),
    .lo_in   (lo_in),
    .busy    (busy),
    .done    (done),
    .hilo_we (hilo_we),
    .gpr_we  (gpr_we),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  int tests = 0;
  int fails = 0;

  typedef struct {
    multicycle_t t;
    logic        m;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] eh;
    logic [31:0] el;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one op in the current cycle and follows it to its done pulse.
  task automatic run_op(input string nm, input multicycle_t t, input logic m,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input int lat);
    int seen;
    int busy_bad;
    mtype  = t;
    is_mul = m;
    src_a  = a;
    src_b  = b;
    start  = 1'b1;
    #1;
    chk({nm, " busy@accept"}, 32'(busy), 32'd1);
    seen     = -1;
    busy_bad = 0;
    for (int c = 1; c <= 60 && seen < 0; c++) begin
      tick();
      start = 1'b0;
      #1;
      if (done) seen = c;
      else if (!busy) busy_bad++;
    end
    chk({nm, " latency"}, 32'(seen), 32'(lat));
    chk({nm, " busy low before done"}, 32'(busy_bad), 32'd0);
    chk({nm, " busy@done"}, 32'(busy), 32'd0);
    chk({nm, " hilo_we"}, 32'(hilo_we), 32'(!m));
    chk({nm, " gpr_we"}, 32'(gpr_we), 32'(m));
    chk({nm, " hi"}, hi_out, eh);
    chk({nm, " lo"}, lo_out, el);
    tick();
    #1;
    chk({nm, " done one cycle"}, 32'(done), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    int bad;

    vecs[0]  = '{M_MULT,  1'b0, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 3};
    vecs[1]  = '{M_MULTU, 1'b0, 32'hFFFF_FFFE, 32'd3,        32'h0000_0002, 32'hFFFF_FFFA, 3};
    vecs[2]  = '{M_DIV,   1'b0, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 34};
    vecs[3]  = '{M_DIVU,  1'b0, 32'd100,       32'd7,        32'd2,         32'd14,        34};
    vecs[4]  = '{M_DIVU,  1'b0, 32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF, 2};
    vecs[5]  = '{M_DIV,   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, 34};
    vecs[6]  = '{M_DIV,   1'b0, 32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, 34};
    vecs[7]  = '{M_DIV,   1'b0, 32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, 2};
    vecs[8]  = '{M_MULT,  1'b1, 32'd7,         32'hFFFF_FFFA, 32'hFFFF_FFFF, 32'hFFFF_FFD6, 3};
    vecs[9]  = '{M_MULTU, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3};
    vecs[10] = '{M_MULT,  1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 3};
    vecs[11] = '{M_DIVU,  1'b0, 32'hFFFF_FFFF, 32'd1,        32'd0,         32'hFFFF_FFFF, 34};
    vecs[12] = '{M_DIVU,  1'b0, 32'd5,         32'd10,       32'd5,         32'd0,         34};
    vecs[13] = '{M_DIV,   1'b0, 32'hFFFF_FFF8, 32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'd2,        34};

    resetn = 1'b0;
    start  = 1'b0;
    flush  = 1'b0;
    mtype  = M_MULT;
    is_mul = 1'b0;
    src_a  = '0;
    src_b  = '0;
    hi_in  = '0;
    lo_in  = '0;
    repeat (3) tick();
    resetn = 1'b1;
    #1;
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset hilo_we", 32'(hilo_we), 32'd0);
    chk("reset gpr_we", 32'(gpr_we), 32'd0);
    chk("reset hi", hi_out, 32'd0);
    chk("reset lo", lo_out, 32'd0);

    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].t, vecs[i].m, vecs[i].a, vecs[i].b,
             vecs[i].eh, vecs[i].el, vecs[i].lat);
    end

    // start held high: operand changes while busy and start in DONE are ignored
    mtype  = M_MULT;
    is_mul = 1'b0;
    src_a  = 32'hFFFF_FFFE;
    src_b  = 32'd3;
    start  = 1'b1;
    #1;
    chk("held c0 busy", 32'(busy), 32'd1);
    tick();
    src_a = 32'd5;
    src_b = 32'd5;
    #1;
    chk("held c1 busy", 32'(busy), 32'd1);
    tick();
    #1;
    chk("held c2 busy", 32'(busy), 32'd1);
    tick();
    #1;
    chk("held c3 done", 32'(done), 32'd1);
    chk("held c3 busy", 32'(busy), 32'd0);
    chk("held c3 hi", hi_out, 32'hFFFF_FFFF);
    chk("held c3 lo", lo_out, 32'hFFFF_FFFA);
    tick();
    #1;
    chk("held c4 reaccept busy", 32'(busy), 32'd1);
    seen = -1;
    for (int c = 5; c <= 40 && seen < 0; c++) begin
      tick();
      start = 1'b0;
      #1;
      if (done) seen = c;
    end
    chk("held second done cycle", 32'(seen), 32'd7);
    chk("held second hi", hi_out, 32'd0);
    chk("held second lo", lo_out, 32'd25);
    tick();

    // flush mid-divide keeps prior HI/LO and produces no write
    run_op("pre-flush", M_MULTU, 1'b0, 32'hFFFF_FFFE, 32'd3, 32'd2, 32'hFFFF_FFFA, 3);
    mtype  = M_DIV;
    src_a  = 32'hFFFF_FFF9;
    src_b  = 32'd2;
    start  = 1'b1;
    #1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    #1;
    chk("flush c10 busy", 32'(busy), 32'd1);
    tick();
    flush = 1'b0;
    #1;
    chk("flush c11 busy", 32'(busy), 32'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || hilo_we || gpr_we) bad++;
      tick();
      #1;
    end
    chk("flush no write", 32'(bad), 32'd0);
    chk("flush hi kept", hi_out, 32'd2);
    chk("flush lo kept", lo_out, 32'hFFFF_FFFA);
    run_op("post-flush MUL", M_MULT, 1'b1, 32'd7, 32'hFFFF_FFFA,
           32'hFFFF_FFFF, 32'hFFFF_FFD6, 3);

    // start and flush together: nothing accepted
    mtype = M_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    flush = 1'b1;
    #1;
    chk("start+flush busy", 32'(busy), 32'd0);
    tick();
    start = 1'b0;
    flush = 1'b0;
    #1;
    chk("start+flush next busy", 32'(busy), 32'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (done || busy) bad++;
      tick();
      #1;
    end
    chk("start+flush no op", 32'(bad), 32'd0);
    chk("start+flush hi kept", hi_out, 32'hFFFF_FFFF);

    // reset at cycle 5 of a divide
    mtype = M_DIVU;
    src_a = 32'd100;
    src_b = 32'd7;
    start = 1'b1;
    #1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    #1;
    chk("midreset busy", 32'(busy), 32'd0);
    chk("midreset done", 32'(done), 32'd0);
    chk("midreset hilo_we", 32'(hilo_we), 32'd0);
    chk("midreset gpr_we", 32'(gpr_we), 32'd0);
    chk("midreset hi", hi_out, 32'd0);
    chk("midreset lo", lo_out, 32'd0);
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      if (done) bad++;
      tick();
      #1;
    end
    chk("midreset no done", 32'(bad), 32'd0);
    run_op("post-reset DIVU", M_DIVU, 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 34);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
